// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one combinational ALU between two
//            valid/ready requesters, with settle delay and registered response.
// Options  : ALU_ARB_STATS_EN adds per-requester grant counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_id,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    localparam logic [3:0] C_SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               id_q, id_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_id_q, rsp_id_d;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_idle;

    // On a tie the requester that did not win last time is favoured.
    assign w_grant0   = req0_valid & (~req1_valid | last_grant_q);
    assign w_grant1   = req1_valid & (~req0_valid | ~last_grant_q);
    assign w_idle     = (state_q == S_IDLE);
    assign req0_ready = rst_n & w_idle & w_grant0;
    assign req1_ready = rst_n & w_idle & w_grant1;

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_id     = rsp_id_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready | req1_ready) begin
                    id_d    = req1_ready;
                    a_d     = req1_ready ? req1_a   : req0_a;
                    b_d     = req1_ready ? req1_b   : req0_b;
                    sel_d   = req1_ready ? req1_sel : req0_sel;
                    cnt_d   = C_SETTLE_M1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_data_d   = alu_out;
                    rsp_carry_d  = alu_carry;
                    rsp_id_d     = id_q;
                    rsp_valid_d  = 1'b1;
                    last_grant_d = id_q;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= '0;
            id_q         <= 1'b0;
            cnt_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] gcnt0_q;
    logic [15:0] gcnt1_q;

    // Clear takes priority over a same-cycle grant; counts saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt0_q <= 16'd0;
            gcnt1_q <= 16'd0;
        end else if (stats_clr) begin
            gcnt0_q <= 16'd0;
            gcnt1_q <= 16'd0;
        end else begin
            if (req0_ready && (gcnt0_q != 16'hFFFF)) gcnt0_q <= gcnt0_q + 16'd1;
            if (req1_ready && (gcnt1_q != 16'hFFFF)) gcnt1_q <= gcnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = gcnt0_q;
    assign grant_cnt1 = gcnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter (SETTLE=1 main instance, SETTLE=4
//            instance for mid-operation reset). Honours ALU_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       carry;
    } exp_t;

    logic clk;
    logic rst_n, d4_rst_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0] req0_sel, req1_sel;
    logic rsp_valid, rsp_ready, rsp_carry, rsp_id;
    logic [7:0] rsp_data, alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic alu_carry;

    logic d4_req0_valid, d4_req0_ready, d4_req1_valid, d4_req1_ready;
    logic [7:0] d4_req0_a, d4_req0_b, d4_req1_a, d4_req1_b;
    logic [3:0] d4_req0_sel, d4_req1_sel;
    logic d4_rsp_valid, d4_rsp_ready, d4_rsp_carry, d4_rsp_id;
    logic [7:0] d4_rsp_data, d4_alu_a, d4_alu_b, d4_alu_out;
    logic [3:0] d4_alu_sel;
    logic d4_alu_carry;

    logic stats_clr;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, d4_cnt0, d4_cnt1;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    // Team ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor.
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] s);
        case (s)
            4'h0:    alu_f = {1'b0, a} + {1'b0, b};
            4'h1:    alu_f = {1'b0, a} - {1'b0, b};
            4'h2:    alu_f = {1'b0, a & b};
            4'h3:    alu_f = {1'b0, a | b};
            4'h4:    alu_f = {1'b0, a ^ b};
            default: alu_f = 9'd0;
        endcase
    endfunction

    assign {alu_carry, alu_out}       = alu_f(alu_a, alu_b, alu_sel);
    assign {d4_alu_carry, d4_alu_out} = alu_f(d4_alu_a, d4_alu_b, d4_alu_sel);

    alu_arbiter #(.WIDTH(8), .SEL_W(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry)
`ifdef ALU_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    alu_arbiter #(.WIDTH(8), .SEL_W(4), .SETTLE(4)) dut4 (
        .clk(clk), .rst_n(d4_rst_n),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_a(d4_req0_a),
        .req0_b(d4_req0_b), .req0_sel(d4_req0_sel),
        .req1_valid(d4_req1_valid), .req1_ready(d4_req1_ready), .req1_a(d4_req1_a),
        .req1_b(d4_req1_b), .req1_sel(d4_req1_sel),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_data(d4_rsp_data),
        .rsp_carry(d4_rsp_carry), .rsp_id(d4_rsp_id),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel),
        .alu_out(d4_alu_out), .alu_carry(d4_alu_carry)
`ifdef ALU_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt0(d4_cnt0), .grant_cnt1(d4_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per accepted response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id",    {31'd0, rsp_id},    {31'd0, e.id});
                chk("rsp_data",  {24'd0, rsp_data},  {24'd0, e.data});
                chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.carry});
            end
        end
    end

    task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] s, input logic [7:0] ed, input logic ec,
                         input bit chk_lat);
        int   waits;
        int   lat;
        logic rdy;
        exp_t e;
        @(posedge clk); #1;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = s; end
        else            begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = s; end
        waits = 0;
        rdy   = 1'b0;
        while (!rdy && waits < 50) begin
            @(negedge clk);
            waits++;
            rdy = (id == 1'b0) ? req0_ready : req1_ready;
        end
        if (!rdy) chk("issue_timeout", 32'd1, 32'd0);
        e.id = id; e.data = ed; e.carry = ec;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Scramble the operands to prove the in-flight op was latched.
        if (id == 1'b0) begin req0_valid = 1'b0; req0_a = ~a; req0_b = ~b; end
        else            begin req1_valid = 1'b0; req1_a = ~a; req1_b = ~b; end
        if (chk_lat) begin
            chk("ready_same_cycle", waits, 32'd1);
            lat = 1;
            while (lat < 20) begin
                @(negedge clk);
                if (rsp_valid) break;
                lat++;
            end
            chk("latency", lat, 32'd2);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int   acc;
        int   last_acc;
        int   lat;
        bit   seen;
        exp_t e;
        rst_n = 1'b0; d4_rst_n = 1'b0; stats_clr = 1'b0;
        rsp_ready = 1'b1; d4_rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_sel = 4'h0;
        req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_sel = 4'h2;
        d4_req0_valid = 1'b0; d4_req0_a = 8'h00; d4_req0_b = 8'h00; d4_req0_sel = 4'h0;
        d4_req1_valid = 1'b0; d4_req1_a = 8'h11; d4_req1_b = 8'h22; d4_req1_sel = 4'h0;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
        chk("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("rst_alu_a",     {24'd0, alu_a},     32'd0);
        chk("rst_alu_sel",   {28'd0, alu_sel},   32'd0);
        chk("rst_ready",     {30'd0, req0_ready, req1_ready}, 32'd0);

        // Contention: six back-to-back ops must alternate 0,1,0,1,...
        for (int i = 0; i < 6; i++) begin
            e.id    = i[0];
            e.data  = i[0] ? 8'h30 : 8'h07;
            e.carry = 1'b0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; d4_rst_n = 1'b1;
        acc = 0; last_acc = 0;
        for (int c = 0; c < 200 && acc < 6; c++) begin
            @(negedge clk);
            chk("both_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_ready || req1_ready) begin
                if (acc > 0) chk("issue_interval", c - last_acc, 32'd3);
                last_acc = c;
                acc++;
            end
        end
        chk("contention_accepts", acc, 32'd6);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        issue(1'b0, 8'h0A, 8'h02, 4'h0, 8'h0C, 1'b0, 1'b1);
        drain();
        issue(1'b1, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1, 1'b1);
        drain();
        issue(1'b0, 8'h05, 8'h07, 4'h1, 8'hFE, 1'b1, 1'b1);
        drain();
        issue(1'b1, 8'hA5, 8'h0F, 4'h4, 8'hAA, 1'b0, 1'b1);
        drain();

        // Backpressure in RESP with both requesters waiting.
        rsp_ready = 1'b0;
        issue(1'b0, 8'h10, 8'h20, 4'h0, 8'h30, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        chk("bp_rsp_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_sel = 4'h0;
        req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h09; req1_sel = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data",  {24'd0, rsp_data},  32'h30);
            chk("bp_id",    {31'd0, rsp_id},    32'd0);
            chk("bp_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("bp_next_grant", {30'd0, req0_ready, req1_ready}, 32'd1);
        e.id = 1'b1; e.data = 8'h10; e.carry = 1'b0; exp_q.push_back(e);
        e.id = 1'b0; e.data = 8'h02; e.carry = 1'b0; exp_q.push_back(e);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req0_ready;
        end
        chk("bp_req0_granted", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain();

        // SETTLE=4 instance: one full op, then reset during EXEC cycle 2.
        @(posedge clk); #1;
        d4_req0_valid = 1'b1; d4_req0_a = 8'h05; d4_req0_b = 8'h06; d4_req0_sel = 4'h0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = d4_req0_ready;
        end
        chk("d4_accept", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        d4_req0_valid = 1'b0;
        lat = 1;
        while (lat < 30) begin
            @(negedge clk);
            if (d4_rsp_valid) break;
            lat++;
        end
        chk("d4_latency", lat, 32'd5);
        chk("d4_data", {24'd0, d4_rsp_data}, 32'h0B);
        chk("d4_id",   {31'd0, d4_rsp_id},   32'd0);
        @(posedge clk); #1;
        d4_req0_valid = 1'b1; d4_req0_a = 8'h09; d4_req0_b = 8'h01;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = d4_req0_ready;
        end
        chk("d4_accept2", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        d4_req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("d4_alu_a_exec", {24'd0, d4_alu_a}, 32'h09);
        #2 d4_rst_n = 1'b0;
        #1;
        chk("d4_rst_valid", {31'd0, d4_rsp_valid}, 32'd0);
        chk("d4_rst_data",  {24'd0, d4_rsp_data},  32'd0);
        chk("d4_rst_alu",   {d4_alu_a, d4_alu_b, 12'd0, d4_alu_sel}, 32'd0);
        @(posedge clk); #1;
        d4_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d4_rsp_valid) seen = 1'b1;
        end
        chk("d4_no_rsp", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
        d4_req0_valid = 1'b1; d4_req1_valid = 1'b1;
        @(negedge clk);
        chk("d4_tie_after_rst", {30'd0, d4_req0_ready, d4_req1_ready}, 32'd2);
        @(posedge clk); #1;
        d4_req0_valid = 1'b0; d4_req1_valid = 1'b0;

`ifdef ALU_ARB_STATS_EN
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        issue(1'b0, 8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0);
        issue(1'b1, 8'h02, 8'h02, 4'h0, 8'h04, 1'b0, 1'b0);
        issue(1'b0, 8'h03, 8'h03, 4'h0, 8'h06, 1'b0, 1'b0);
        issue(1'b1, 8'h04, 8'h04, 4'h0, 8'h08, 1'b0, 1'b0);
        issue(1'b0, 8'h05, 8'h05, 4'h0, 8'h0A, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        chk("grant_cnt0", {16'd0, grant_cnt0}, 32'd3);
        chk("grant_cnt1", {16'd0, grant_cnt1}, 32'd2);
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        chk("grant_clr", {grant_cnt0, grant_cnt1}, 32'd0);
`endif

        drain();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit `alu` (operands A/B, 4-bit select, 8-bit result, carry-out) between two requesters.
- Each requester presents an operation with a valid/ready handshake.
- The block grants one requester at a time, round-robin on contention, and holds the ALU inputs stable for a programmable settle time.
- It registers the result and carry, then returns them with the winner's ID on a valid/ready response channel. Sits between requester logic and the shared `alu` instance.

Parameters:
- WIDTH, 8, operand/result width; must match the attached ALU.
- SEL_W, 4, ALU select width.
- SETTLE, 1, cycles ALU inputs are held before result capture; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_sel  in  SEL_W  requester 0 ALU select.
- req1_valid / req1_ready / req1_a / req1_b / req1_sel  same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_carry  out  1  captured ALU carry-out.
- rsp_id  out  1  requester that issued the operation.
- alu_a  out  WIDTH  to ALU operand A.
- alu_b  out  WIDTH  to ALU operand B.
- alu_sel  out  SEL_W  to ALU select.
- alu_out  in  WIDTH  from ALU result.
- alu_carry  in  1  from ALU carry-out.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; last_grant=1, so requester 0 wins the first tie.
  - Latched operand/select/id regs=0; settle counter=0.
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0.
  - alu_a=alu_b=0, alu_sel=0; req0_ready=req1_ready=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one valid: grant it. Both valid: grant the requester not equal to last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE. The other requester's ready stays 0.
  - On handshake (valid & ready): latch a, b, sel, id; load counter=SETTLE-1; go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_a/alu_b/alu_sel are driven from the latched regs, which are registered and stable for the whole state.
  - Counter decrements each cycle. When counter==0: capture alu_out→rsp_data and alu_carry→rsp_carry; set rsp_id=latched id, rsp_valid=1, last_grant=latched id; go to RESP.
  - With SETTLE=1, capture happens on the first EXEC cycle.
- RESP:
  - rsp_* held constant while rsp_valid=1 and rsp_ready=0 (backpressure for unlimited cycles).
  - On rsp_valid & rsp_ready: rsp_valid=0 next cycle; go to IDLE. rsp_data/carry/id retain their values.
  - No new request is accepted in the handshake cycle; next acceptance is earliest one cycle later.
- In IDLE and RESP, alu_a/alu_b/alu_sel keep their last driven values. This avoids needless toggling.
- Latency from request handshake to rsp_valid=1: SETTLE+1 cycles.
- Minimum issue interval: SETTLE+2 cycles when rsp_ready is tied high.
- Requester inputs may change after the handshake without affecting the in-flight operation.
- The select value is passed through unchecked; unused ALU codes produce whatever the ALU returns.
- Reset mid-EXEC/RESP: the operation is dropped, no response is produced, and all outputs return to reset values immediately.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each). These count accepted requests per requester and saturate at 16'hFFFF.
  - Adds input stats_clr (1 bit). It synchronously zeroes both counters; clear wins over a same-cycle increment.
  - Counters reset to 0 on rst_n.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op: bench connects the team ALU (sel 4'h0 = A+B). req0 a=8'h0A, b=8'h02, sel=4'h0, SETTLE=1 → req0_ready in the same cycle; rsp_valid 2 cycles after handshake with rsp_data=8'h0C, rsp_carry=0, rsp_id=0.
- Carry: req1 a=8'hFF, b=8'h01, sel=4'h0 → rsp_data=8'h00, rsp_carry=1, rsp_id=1.
- Contention: both valid from the first cycle after reset, rsp_ready=1, 6 ops → rsp_id sequence 0,1,0,1,0,1; the loser's ready stays 0 while the other is in flight.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP → rsp_* stable and no reqN_ready asserted; release → rsp_valid drops next cycle, and the next grant occurs one cycle later.
- Reset mid-EXEC with SETTLE=4: assert rst_n=0 during cycle 2 of EXEC → all outputs 0 asynchronously; after release no response appears, and the first tie grants requester 0.
- With ALU_ARB_STATS_EN: issue 3 ops from req0 and 2 from req1 → grant_cnt0=3, grant_cnt1=2; pulse stats_clr → both read 0.
